// File: rtl/lane_splitter.sv
// Splits one LANES*LANE_W word across per-lane outputs (parallel) or streams it slice by slice on lane 0 (serial); 1-cycle latency.
// in_ready stalls until every pending lane drains this cycle (parallel) or the last serial slice is being taken.
module lane_splitter #(
    parameter int LANE_W = 16,
    parameter int LANES  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   in_data,
    input  logic                      in_mode,
    output logic [LANES-1:0]          out_valid,
    input  logic [LANES-1:0]          out_ready,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic [15:0]               word_count
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {EMPTY, PAR, SER} state_t;

    state_t                       state;
    logic [IDX_W-1:0]             idx;
    logic [(LANES-1)*LANE_W-1:0]  hold;

    logic                         in_xfer;
    logic [LANES-1:0]             lane_xfer;
    logic [LANES-1:0]             par_left;
    logic [LANE_W-1:0]            next_slice;

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state)
                EMPTY:   in_ready = 1'b1;
                PAR:     in_ready = &(~out_valid | out_ready);
                SER:     in_ready = (idx == LAST) && out_ready[0];
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign in_xfer   = in_valid & in_ready;
    assign lane_xfer = out_valid & out_ready;
    assign par_left  = out_valid & ~out_ready;

    // hold[] keeps slices 1..LANES-1, so slice idx+1 of the word sits at hold index idx
    always_comb begin
        next_slice = '0;
        for (int k = 0; k < LANES - 1; k++) begin
            if (idx == IDX_W'(k))
                next_slice = hold[k*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            idx        <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            hold       <= '0;
            word_count <= '0;
        end else if (in_xfer) begin
            word_count <= word_count + 16'd1;
            if (!in_mode) begin
                out_data  <= in_data;
                out_valid <= '1;
                state     <= PAR;
            end else begin
                out_data[LANE_W-1:0] <= in_data[LANE_W-1:0];
                out_valid            <= {{(LANES-1){1'b0}}, 1'b1};
                hold                 <= in_data[LANES*LANE_W-1:LANE_W];
                idx                  <= '0;
                state                <= SER;
            end
        end else begin
            case (state)
                PAR: begin
                    out_valid <= par_left;
                    if (par_left == '0)
                        state <= EMPTY;
                end
                SER: begin
                    if (lane_xfer[0]) begin
                        if (idx == LAST) begin
                            out_valid <= '0;
                            idx       <= '0;
                            state     <= EMPTY;
                        end else begin
                            idx                  <= idx + 1'b1;
                            out_data[LANE_W-1:0] <= next_slice;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_splitter.sv
// Directed checks of lane_splitter: a 2x16 instance for parallel/mode/counter cases, a 4x8 instance for serial/reset cases.
module tb_lane_splitter;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid2, in_mode2, in_ready2;
    logic [31:0] in_data2, out_data2;
    logic [1:0]  out_valid2, out_ready2;
    logic [15:0] word_count2;

    logic        in_valid4, in_mode4, in_ready4;
    logic [31:0] in_data4, out_data4;
    logic [3:0]  out_valid4, out_ready4;
    logic [15:0] word_count4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lane_splitter #(.LANE_W(16), .LANES(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_mode(in_mode2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .word_count(word_count2)
    );

    lane_splitter #(.LANE_W(8), .LANES(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .word_count(word_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] ser_exp [4];
        ser_exp[0] = 8'h11; ser_exp[1] = 8'h22; ser_exp[2] = 8'h33; ser_exp[3] = 8'h44;

        in_valid2 = 0; in_mode2 = 0; in_data2 = '0; out_ready2 = '0;
        in_valid4 = 0; in_mode4 = 0; in_data4 = '0; out_ready4 = '0;
        reset = 0;
        #1 reset = 1;
        #1;
        chk("rst_in_ready", in_ready2, 0);
        chk("rst_out_valid", out_valid2, 0);
        chk("rst_out_data", out_data2, 0);
        chk("rst_word_count", word_count2, 0);

        next();
        reset = 0;
        #1;
        chk("post_rst_in_ready", in_ready2, 1);

        // parallel fan-out, back-to-back
        out_ready2 = 2'b11; in_valid2 = 1; in_mode2 = 0; in_data2 = 32'hAAAA5555;
        next();
        chk("par_out_valid", out_valid2, 2'b11);
        chk("par_out_data", out_data2, 32'hAAAA5555);
        chk("par_wc1", word_count2, 1);
        in_data2 = 32'h12345678;
        #1;
        chk("par_b2b_in_ready", in_ready2, 1);
        next();
        chk("par_b2b_data", out_data2, 32'h12345678);
        chk("par_wc2", word_count2, 2);
        in_data2 = 32'hAAAA5555;
        next();

        // lane 1 stalled
        in_valid2 = 0; out_ready2 = 2'b01;
        #1;
        chk("stall_in_ready0", in_ready2, 0);
        next();
        chk("stall_out_valid", out_valid2, 2'b10);
        chk("stall_lane1", out_data2[31:16], 16'hAAAA);
        chk("stall_in_ready1", in_ready2, 0);
        next();
        chk("stall_lane1_hold", out_data2[31:16], 16'hAAAA);
        chk("stall_out_valid2", out_valid2, 2'b10);
        out_ready2 = 2'b11;
        #1;
        chk("unstall_in_ready", in_ready2, 1);
        next();
        chk("drained_out_valid", out_valid2, 2'b00);
        chk("empty_in_ready", in_ready2, 1);

        // mode switch: parallel word then serial word
        in_valid2 = 1; in_mode2 = 0; in_data2 = 32'hBBBBCCCC;
        next();
        in_mode2 = 1; in_data2 = 32'hDDDDEEEE;
        #1;
        chk("sw_par_valid", out_valid2, 2'b11);
        chk("sw_par_data", out_data2, 32'hBBBBCCCC);
        chk("sw_in_ready", in_ready2, 1);
        next();
        in_valid2 = 0; in_mode2 = 0;
        #1;
        chk("sw_ser_valid0", out_valid2, 2'b01);
        chk("sw_ser_lane0_s0", out_data2[15:0], 16'hEEEE);
        chk("sw_ser_lane1_hold", out_data2[31:16], 16'hBBBB);
        chk("sw_ser_in_ready0", in_ready2, 0);
        next();
        chk("sw_ser_valid1", out_valid2, 2'b01);
        chk("sw_ser_lane0_s1", out_data2[15:0], 16'hDDDD);
        chk("sw_ser_in_ready1", in_ready2, 1);
        next();
        chk("sw_done_valid", out_valid2, 2'b00);
        chk("sw_wc", word_count2, 5);

        // serial, LANES=4
        out_ready4 = 4'b0001; in_valid4 = 1; in_mode4 = 1; in_data4 = 32'h44332211;
        #1;
        chk("ser4_accept_ready", in_ready4, 1);
        next();
        in_valid4 = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ser4_lane0", out_data4[7:0], ser_exp[i]);
            chk("ser4_valid", out_valid4, 4'b0001);
            chk("ser4_in_ready", in_ready4, (i == 3) ? 1 : 0);
            next();
        end
        chk("ser4_done_valid", out_valid4, 0);
        chk("ser4_wc", word_count4, 1);

        // reset during serial at idx=1
        in_valid4 = 1; in_data4 = 32'h88776655;
        next();
        in_valid4 = 0;
        next();
        chk("rst_mid_idx1_lane0", out_data4[7:0], 8'h66);
        reset = 1;
        #1;
        chk("rst_mid_valid", out_valid4, 0);
        chk("rst_mid_wc", word_count4, 0);
        chk("rst_mid_data", out_data4, 0);
        chk("rst_mid_in_ready", in_ready4, 0);
        chk("rst_mid_wc2", word_count2, 0);
        next();
        reset = 0; in_valid4 = 1; in_data4 = 32'hDDCCBBAA;
        #1;
        chk("rst_after_ready", in_ready4, 1);
        next();
        in_valid4 = 0;
        #1;
        chk("rst_after_slice0", out_data4[7:0], 8'hAA);
        chk("rst_after_valid", out_valid4, 4'b0001);
        chk("rst_after_wc", word_count4, 1);
        repeat (4) next();
        chk("rst_after_drained", out_valid4, 0);

        // word counter wrap
        out_ready2 = 2'b11; in_mode2 = 0; in_valid2 = 1; in_data2 = 32'h0F0F0F0F;
        repeat (65535) @(posedge clock);
        #1;
        chk("wc_ffff", word_count2, 16'hFFFF);
        next();
        chk("wc_wrap0", word_count2, 16'h0000);
        next();
        in_valid2 = 0;
        #1;
        chk("wc_65537", word_count2, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
